// File: rtl/dm_pkg.sv
// Shared types for the data-memory access controller: request opcodes,
// controller states, bus widths and the opcode-to-strobe mapping.
package dm_pkg;

  localparam int DM_ADDR_W = 9;
  localparam int DM_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One-hot strobe bundle {pop, push, store, load} for a request opcode
  function automatic logic [3:0] op_strobe(op_t op);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_LOAD:  s = 4'b0001;
      OP_STORE: s = 4'b0010;
      OP_PUSH:  s = 4'b0100;
      OP_POP:   s = 4'b1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dm_sp_unit.sv
// Stack pointer register for the DM access controller.
// sp points at the next free slot; the stack grows downward from SP_INIT.
// With DM_STACK_GUARD_EN defined the full/empty flags are live, otherwise
// they are held low so the pointer simply wraps modulo 2^16.
module dm_sp_unit
  import dm_pkg::*;
#(
  parameter logic [DM_DATA_W-1:0] SP_INIT     = 16'hFFFF,
  parameter int                   STACK_DEPTH = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sp_dec,
  input  logic                 sp_inc,
  output logic [DM_DATA_W-1:0] sp,
  output logic [DM_DATA_W-1:0] sp_plus1,
  output logic                 full,
  output logic                 empty
);

  localparam logic [DM_DATA_W-1:0] SP_FULL = SP_INIT - DM_DATA_W'(STACK_DEPTH);

  logic [DM_DATA_W-1:0] sp_q;
  logic [DM_DATA_W-1:0] sp_d;

  // Next pointer: a committed push moves down, a committed pop moves up
  always_comb begin
    sp_d = sp_q;
    if (sp_dec) begin
      sp_d = sp_q - 16'd1;
    end else if (sp_inc) begin
      sp_d = sp_q + 16'd1;
    end
  end

  // Pointer register, returns to the empty-stack value on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= SP_INIT;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp       = sp_q;
  assign sp_plus1 = sp_q + 16'd1;

`ifdef DM_STACK_GUARD_EN
  assign full  = (sp_q == SP_FULL);
  assign empty = (sp_q == SP_INIT);
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator side of the data-memory port. Takes one load/store/push/pop
// request at a time, fires a single one-cycle strobe to DM, waits RD_LAT
// cycles for read data and returns a one-cycle response pulse.
// Optional stack over/underflow guard: define DM_STACK_GUARD_EN.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter logic [DM_DATA_W-1:0] SP_INIT     = 16'hFFFF,
  parameter int                   STACK_DEPTH = 512,
  parameter int                   RD_LAT      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  op_t                  req_op,
  input  logic [DM_ADDR_W-1:0] req_addr,
  input  logic [DM_DATA_W-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DM_DATA_W-1:0] resp_data,
  output logic                 resp_fault,
  output logic [DM_DATA_W-1:0] sp_out,
  output logic                 dm_load,
  output logic                 dm_store,
  output logic                 dm_push,
  output logic                 dm_pop,
  output logic [DM_ADDR_W-1:0] dm_address,
  output logic [DM_DATA_W-1:0] dm_sp,
  output logic [DM_DATA_W-1:0] dm_rez,
  input  logic [DM_DATA_W-1:0] dm_data_out
);

  localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic                 fault_q, fault_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           strobe_q, strobe_d;
  logic [DM_ADDR_W-1:0] addr_q, addr_d;
  logic [DM_DATA_W-1:0] dm_sp_q, dm_sp_d;
  logic [DM_DATA_W-1:0] rez_q, rez_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DM_DATA_W-1:0] resp_data_q, resp_data_d;
  logic                 resp_fault_q, resp_fault_d;

  logic [DM_DATA_W-1:0] sp;
  logic [DM_DATA_W-1:0] sp_plus1;
  logic                 full;
  logic                 empty;
  logic                 req_fault;
  logic                 sp_dec;
  logic                 sp_inc;

  // Stack pointer only moves when a non-faulted push/pop completes
  assign sp_dec = (state_q == RESP) && !fault_q && (op_q == OP_PUSH);
  assign sp_inc = (state_q == RESP) && !fault_q && (op_q == OP_POP);

  dm_sp_unit #(
    .SP_INIT    (SP_INIT),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_sp_unit (
    .clk     (clk),
    .rst     (rst),
    .sp_dec  (sp_dec),
    .sp_inc  (sp_inc),
    .sp      (sp),
    .sp_plus1(sp_plus1),
    .full    (full),
    .empty   (empty)
  );

  assign req_fault = ((req_op == OP_PUSH) && full) || ((req_op == OP_POP) && empty);

  // Next-state and next-output logic for the request/strobe/response sequence
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;
    strobe_d     = 4'b0000;
    addr_d       = addr_q;
    dm_sp_d      = dm_sp_q;
    rez_d        = rez_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          rez_d   = req_wdata;
          dm_sp_d = (req_op == OP_POP) ? sp_plus1 : sp;
          fault_d = req_fault;
          if (req_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d  = ISSUE;
            strobe_d = op_strobe(req_op);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if ((op_q == OP_LOAD) || (op_q == OP_POP)) begin
            resp_data_d = dm_data_out;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single register bank for state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_LOAD;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
      strobe_q     <= 4'b0000;
      addr_q       <= '0;
      dm_sp_q      <= SP_INIT;
      rez_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
      strobe_q     <= strobe_d;
      addr_q       <= addr_d;
      dm_sp_q      <= dm_sp_d;
      rez_q        <= rez_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign sp_out     = sp;
  assign dm_load    = strobe_q[0];
  assign dm_store   = strobe_q[1];
  assign dm_push    = strobe_q[2];
  assign dm_pop     = strobe_q[3];
  assign dm_address = addr_q;
  assign dm_sp      = dm_sp_q;
  assign dm_rez     = rez_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: a behavioural DM memory on the
// strobe side and a stack/memory reference model that predicts every response.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  localparam logic [15:0] SP_INIT     = 16'hFFFF;
  localparam int          STACK_DEPTH = 512;
  localparam int          RD_LAT      = 1;
`ifdef DM_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_fault;
  logic [15:0] sp_out;
  logic        dm_load, dm_store, dm_push, dm_pop;
  logic [8:0]  dm_address;
  logic [15:0] dm_sp;
  logic [15:0] dm_rez;
  logic [15:0] dm_data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: logical memory, logical stack storage, pointer
  logic [15:0] ref_mem [0:511];
  logic [15:0] ref_stk [0:65535];
  logic [15:0] ref_sp;
  logic [15:0] ref_last_data;

  // Behavioural DM storage
  logic [15:0] dm_mem [0:511];
  logic [15:0] dm_stk [0:65535];

  always #5 clk = ~clk;

  dm_access_ctrl #(
    .SP_INIT    (SP_INIT),
    .STACK_DEPTH(STACK_DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .sp_out     (sp_out),
    .dm_load    (dm_load),
    .dm_store   (dm_store),
    .dm_push    (dm_push),
    .dm_pop     (dm_pop),
    .dm_address (dm_address),
    .dm_sp      (dm_sp),
    .dm_rez     (dm_rez),
    .dm_data_out(dm_data_out)
  );

  // DM: samples strobes on posedge; read data valid for one cycle, noise otherwise
  always @(posedge clk) begin
    if (dm_store) dm_mem[dm_address] <= dm_rez;
    if (dm_push)  dm_stk[dm_sp] <= dm_rez;
    if (dm_load)     dm_data_out <= dm_mem[dm_address];
    else if (dm_pop) dm_data_out <= dm_stk[dm_sp];
    else             dm_data_out <= 16'($urandom);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkDmFields(input op_t op, input logic [8:0] addr, input logic [15:0] wdata,
                               input logic [15:0] exp_dmsp);
    case (op)
      OP_LOAD:  checkOutput("dm_address_load", dm_address, addr);
      OP_STORE: begin
        checkOutput("dm_address_store", dm_address, addr);
        checkOutput("dm_rez_store", dm_rez, wdata);
      end
      OP_PUSH: begin
        checkOutput("dm_sp_push", dm_sp, exp_dmsp);
        checkOutput("dm_rez_push", dm_rez, wdata);
      end
      OP_POP:   checkOutput("dm_sp_pop", dm_sp, exp_dmsp);
    endcase
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_sp = SP_INIT;
    ref_last_data = 16'h0000;
  endtask

  task automatic checkResetState();
    checkOutput("rst_ready", req_ready, 1'b1);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_resp_fault", resp_fault, 1'b0);
    checkOutput("rst_resp_data", resp_data, 16'h0000);
    checkOutput("rst_sp_out", sp_out, SP_INIT);
    checkOutput("rst_strobes", {dm_pop, dm_push, dm_store, dm_load}, 4'b0000);
    checkOutput("rst_dm_address", dm_address, 9'h000);
    checkOutput("rst_dm_sp", dm_sp, SP_INIT);
    checkOutput("rst_dm_rez", dm_rez, 16'h0000);
  endtask

  // One transaction: start and end on a negedge inside an IDLE cycle
  task automatic applyStimulus(input op_t op, input logic [8:0] addr, input logic [15:0] wdata,
                               input bit hold_valid);
    logic [15:0] full_sp, exp_sp, exp_data, exp_dmsp;
    logic [3:0]  exp_strobe, strobes;
    bit          exp_fault, done;
    int          exp_lat, lat, nstrobe;
    full_sp   = SP_INIT - 16'(STACK_DEPTH);
    exp_fault = GUARD && (((op == OP_PUSH) && (ref_sp == full_sp)) ||
                          ((op == OP_POP) && (ref_sp == SP_INIT)));
    exp_strobe = exp_fault ? 4'b0000 : (4'b0001 << op);
    exp_lat    = exp_fault ? 1 : RD_LAT + 2;
    exp_data   = ref_last_data;
    exp_sp     = ref_sp;
    exp_dmsp   = ref_sp;
    if (!exp_fault) begin
      case (op)
        OP_LOAD: exp_data = ref_mem[addr];
        OP_PUSH: exp_sp = ref_sp - 16'd1;
        OP_POP: begin
          exp_dmsp = ref_sp + 16'd1;
          exp_data = ref_stk[exp_dmsp];
          exp_sp   = exp_dmsp;
        end
        default: ;
      endcase
    end

    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    checkOutput("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) req_valid = 1'b0;

    lat = 0;
    nstrobe = 0;
    done = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      if (k > 1) @(negedge clk);
      strobes = {dm_pop, dm_push, dm_store, dm_load};
      checkOutput("req_ready_busy", req_ready, 1'b0);
      if (strobes != 4'b0000) begin
        nstrobe++;
        checkOutput("strobe_kind", strobes, exp_strobe);
        checkOutput("strobe_cycle", k, 1);
        checkDmFields(op, addr, wdata, exp_dmsp);
      end
      if (resp_valid) begin
        done = 1'b1;
        lat = k;
        checkOutput("resp_data", resp_data, exp_data);
        checkOutput("resp_fault", resp_fault, exp_fault);
        if (!exp_fault) checkDmFields(op, addr, wdata, exp_dmsp);
      end
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("strobe_count", nstrobe, exp_fault ? 0 : 1);

    @(negedge clk);
    checkOutput("resp_pulse", resp_valid, 1'b0);
    checkOutput("sp_out", sp_out, exp_sp);
    checkOutput("strobe_idle", {dm_pop, dm_push, dm_store, dm_load}, 4'b0000);

    if (!exp_fault) begin
      case (op)
        OP_STORE: ref_mem[addr] = wdata;
        OP_PUSH:  ref_stk[ref_sp] = wdata;
        default: ;
      endcase
    end
    ref_sp = exp_sp;
    ref_last_data = exp_data;
  endtask

  // Reset during the WAIT cycle of a push must abort it cleanly
  task automatic abortTest();
    doReset();
    req_valid = 1'b1;
    req_op    = OP_PUSH;
    req_addr  = 9'h000;
    req_wdata = 16'hA5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("abort_issue_push", dm_push, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ready", req_ready, 1'b1);
    checkOutput("abort_sp", sp_out, 16'hFFFF);
    checkOutput("abort_no_resp", resp_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_resp_late", resp_valid, 1'b0);
      checkOutput("abort_sp_late", sp_out, 16'hFFFF);
    end
    ref_sp = SP_INIT;
    ref_last_data = 16'h0000;
  endtask

  initial begin
    op_t rop;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 16'h0000;
      dm_mem[i]  = 16'h0000;
    end
    for (int i = 0; i < 65536; i++) begin
      ref_stk[i] = 16'h0000;
      dm_stk[i]  = 16'h0000;
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_LOAD;
    req_addr  = 9'h000;
    req_wdata = 16'h0000;

    doReset();
    checkResetState();

    applyStimulus(OP_STORE, 9'h005, 16'hBEEF, 1'b0);
    applyStimulus(OP_LOAD, 9'h005, 16'h0000, 1'b0);
    checkOutput("load_beef", resp_data, 16'hBEEF);

    applyStimulus(OP_PUSH, 9'h000, 16'h1111, 1'b0);
    checkOutput("push1_sp", sp_out, 16'hFFFE);
    applyStimulus(OP_PUSH, 9'h000, 16'h2222, 1'b0);
    checkOutput("push2_sp", sp_out, 16'hFFFD);
    applyStimulus(OP_POP, 9'h000, 16'h0000, 1'b0);
    checkOutput("pop1_data", resp_data, 16'h2222);
    applyStimulus(OP_POP, 9'h000, 16'h0000, 1'b0);
    checkOutput("pop2_data", resp_data, 16'h1111);
    checkOutput("pop2_sp", sp_out, 16'hFFFF);

`ifdef DM_STACK_GUARD_EN
    doReset();
    applyStimulus(OP_POP, 9'h000, 16'h0000, 1'b0);
    checkOutput("underflow_fault_sp", sp_out, 16'hFFFF);
    for (int i = 0; i < 512; i++) begin
      applyStimulus(OP_PUSH, 9'h000, 16'($urandom), 1'b0);
    end
    applyStimulus(OP_PUSH, 9'h000, 16'hDEAD, 1'b0);
    checkOutput("overflow_sp", sp_out, 16'hFDFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_POP, 9'h000, 16'h0000, 1'b0);
    end
`else
    doReset();
    applyStimulus(OP_POP, 9'h000, 16'h0000, 1'b0);
    checkOutput("wrap_sp", sp_out, 16'h0000);
`endif

    doReset();
    for (int i = 0; i < 6; i++) begin
      rop = op_t'($urandom_range(0, 3));
      applyStimulus(rop, 9'($urandom_range(0, 7)), 16'($urandom), 1'b1);
    end
    req_valid = 1'b0;

    doReset();
    for (int i = 0; i < 80; i++) begin
      rop = op_t'($urandom_range(0, 3));
      applyStimulus(rop, 9'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    abortTest();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
